// File: rtl/scoreboard.sv
// scoreboard -- per-register pending-write tracker for an in-order issue stage.
//
// Each of the 8 architectural registers has a 2-bit count of writes issued
// but not yet written back. Decode is stalled on a RAW hazard, meaning a
// source register is still busy. Decode is also stalled when the destination
// count is already saturated at 3. WAW alone never stalls below count 3.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   iss_valid                       decode presents an instruction
//   iss_ra1/ra2, iss_use1/use2      source addresses and their read enables
//   iss_wr, iss_wa                  destination write enable and address
//   wb_we3/we4, wb_wa3/wa4          writeback ports (mirror regfile we3/we4, wa3/wa4)
//   stall, iss_accept               combinational issue handshake
//   busy[7:0], inflight[4:0]        registered pending view (no lag vs counts)
//   sb_err                          registered sticky underflow flag
//
// Configuration:
//   SCOREBOARD_FWD_EN  when defined, a source whose only pending write is
//                      being written back this cycle does not stall. The
//                      regfile writes on negedge, so the data is already
//                      valid later in the same cycle.
module scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       iss_valid,
    input  logic [2:0] iss_ra1,
    input  logic [2:0] iss_ra2,
    input  logic       iss_use1,
    input  logic       iss_use2,
    input  logic       iss_wr,
    input  logic [2:0] iss_wa,
    input  logic       wb_we3,
    input  logic       wb_we4,
    input  logic [2:0] wb_wa3,
    input  logic [2:0] wb_wa4,
    output logic       stall,
    output logic       iss_accept,
    output logic [7:0] busy,
    output logic [4:0] inflight,
    output logic       sb_err
);

    logic [1:0] cnt_q [8];
    logic [1:0] cnt_d [8];
    logic [7:0] busy_q, busy_d;
    logic [4:0] inflight_q, inflight_d;
    logic       sb_err_q, sb_err_d;
    logic       byp1, byp2;

`ifdef SCOREBOARD_FWD_EN
    // Bypass only when the writeback in flight is the last pending write.
    // An older write completing would leave a newer one still outstanding.
    assign byp1 = (cnt_q[iss_ra1] == 2'd1) &&
                  ((wb_we3 && (wb_wa3 == iss_ra1)) || (wb_we4 && (wb_wa4 == iss_ra1)));
    assign byp2 = (cnt_q[iss_ra2] == 2'd1) &&
                  ((wb_we3 && (wb_wa3 == iss_ra2)) || (wb_we4 && (wb_wa4 == iss_ra2)));
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Stall looks at the current counts only. A writeback freeing a
    // saturated destination becomes visible on the following cycle.
    always_comb begin
        stall = iss_valid &&
                ((iss_use1 && busy_q[iss_ra1] && !byp1) ||
                 (iss_use2 && busy_q[iss_ra2] && !byp2) ||
                 (iss_wr && (cnt_q[iss_wa] == 2'd3)));
        iss_accept = iss_valid && !stall;
    end

    // busy and inflight are derived from the next counts, so they
    // register in step with the counters.
    always_comb begin
        sb_err_d   = sb_err_q;
        inflight_d = 5'd0;
        busy_d     = 8'h00;
        for (int r = 0; r < 8; r++) begin
            logic       inc;
            logic [1:0] dec;
            logic [2:0] tmp;
            logic [2:0] nxt;
            inc = iss_accept && iss_wr && (iss_wa == 3'(r));
            dec = {1'b0, (wb_we3 && (wb_wa3 == 3'(r)))} +
                  {1'b0, (wb_we4 && (wb_wa4 == 3'(r)))};
            // Increment only happens below 3 (a full count stalls), so tmp <= 3.
            tmp = {1'b0, cnt_q[r]} + {2'b00, inc};
            nxt = 3'd0;
            if (tmp < {1'b0, dec}) begin
                cnt_d[r] = 2'd0;
                sb_err_d = 1'b1;
            end else begin
                nxt      = tmp - {1'b0, dec};
                cnt_d[r] = nxt[1:0];
            end
            busy_d[r]  = (cnt_d[r] != 2'd0);
            inflight_d = inflight_d + {3'b000, cnt_d[r]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) cnt_q[r] <= 2'd0;
            busy_q     <= 8'h00;
            inflight_q <= 5'd0;
            sb_err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy     = busy_q;
    assign inflight = inflight_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Directed-vector bench for scoreboard. The expected values are worked out by hand.
module tb_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       iss_valid, iss_use1, iss_use2, iss_wr;
    logic [2:0] iss_ra1, iss_ra2, iss_wa;
    logic       wb_we3, wb_we4;
    logic [2:0] wb_wa3, wb_wa4;
    logic       stall, iss_accept, sb_err;
    logic [7:0] busy;
    logic [4:0] inflight;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scoreboard dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ra1(iss_ra1), .iss_ra2(iss_ra2),
        .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_wr(iss_wr), .iss_wa(iss_wa),
        .wb_we3(wb_we3), .wb_we4(wb_we4), .wb_wa3(wb_wa3), .wb_wa4(wb_wa4),
        .stall(stall), .iss_accept(iss_accept), .busy(busy),
        .inflight(inflight), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_wr = 0;
        iss_ra1 = 0; iss_ra2 = 0; iss_wa = 0;
        wb_we3 = 0; wb_we4 = 0; wb_wa3 = 0; wb_wa4 = 0;
    endtask

    task automatic issue_wr(input logic [2:0] wa);
        iss_valid = 1; iss_wr = 1; iss_wa = wa;
    endtask

    initial begin
        idle();
        reset = 1;
        #2;
        // Reset state. The counts are zero, so a valid source read does not stall.
        iss_valid = 1; iss_use1 = 1; iss_ra1 = 3;
        #1;
        chk("rst_busy", busy, 8'h00);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_stall", stall, 0);
        idle();
        step();
        reset = 0;
        step();

        // Issue a write to r3, then a read of r3 on the next cycle.
        issue_wr(3);
        #1 chk("wr3_accept", iss_accept, 1);
        step();
        chk("wr3_busy", busy, 8'h08);
        chk("wr3_inflight", inflight, 1);
        idle();
        iss_valid = 1; iss_use1 = 1; iss_ra1 = 3;
        #1;
        chk("raw3_stall", stall, 1);
        chk("raw3_accept", iss_accept, 0);

        // A writeback to r3 arrives in the same cycle as the read.
        wb_we3 = 1; wb_wa3 = 3;
        #1;
`ifdef SCOREBOARD_FWD_EN
        chk("byp3_stall", stall, 0);
`else
        chk("byp3_stall", stall, 1);
`endif
        step();
        wb_we3 = 0;
        #1;
        chk("post_wb3_stall", stall, 0);
        chk("post_wb3_busy", busy, 8'h00);
        chk("post_wb3_inflight", inflight, 0);
        chk("post_wb3_err", sb_err, 0);
        idle();
        step();

        // Write r5 three times, which saturates its count at 3.
        issue_wr(5);
        step(); step(); step();
        chk("r5x3_inflight", inflight, 3);
        chk("r5x3_busy", busy, 8'h20);
        #1 chk("r5_full_stall", stall, 1);
        chk("r5_full_accept", iss_accept, 0);
        wb_we4 = 1; wb_wa4 = 5;
        #1 chk("r5_full_wb_stall", stall, 1);
        step();
        wb_we4 = 0;
        chk("r5_after_wb_inflight", inflight, 2);
        #1 chk("r5_retry_stall", stall, 0);
        step();
        chk("r5_retry_inflight", inflight, 3);
        // Drain r5: both ports in one cycle remove 2, then one more.
        idle();
        wb_we3 = 1; wb_wa3 = 5; wb_we4 = 1; wb_wa4 = 5;
        step();
        chk("r5_dual_wb_inflight", inflight, 1);
        wb_we4 = 0;
        step();
        chk("r5_drained_inflight", inflight, 0);
        chk("r5_drained_err", sb_err, 0);
        idle();

        // An increment and a decrement on r2 in the same cycle cancel out.
        issue_wr(2);
        step();
        wb_we3 = 1; wb_wa3 = 2;
        #1 chk("r2_net_stall", stall, 0);
        step();
        chk("r2_net_busy", busy, 8'h04);
        chk("r2_net_inflight", inflight, 1);
        idle();
        iss_valid = 1; iss_use2 = 1; iss_ra2 = 2;
        #1 chk("r2_src2_stall", stall, 1);
        iss_use2 = 0;
        #1 chk("r2_unused_stall", stall, 0);
        idle();
        wb_we4 = 1; wb_wa4 = 2;
        step();
        chk("r2_clear_busy", busy, 8'h00);
        idle();

        // Underflow: r6 holds 1 but both ports write it back.
        issue_wr(6);
        step();
        idle();
        wb_we3 = 1; wb_wa3 = 6; wb_we4 = 1; wb_wa4 = 6;
        step();
        chk("r6_uf_inflight", inflight, 0);
        chk("r6_uf_err", sb_err, 1);
        idle();
        step(); step();
        chk("err_sticky", sb_err, 1);

        // A writeback to idle r0 sets the error and leaves r1 untouched.
        reset = 1; #1 reset = 0;
        chk("rst2_err", sb_err, 0);
        issue_wr(1);
        step();
        idle();
        wb_we3 = 1; wb_wa3 = 0;
        step();
        idle();
        chk("r0_uf_err", sb_err, 1);
        chk("r0_uf_busy", busy, 8'h02);
        chk("r0_uf_inflight", inflight, 1);

        // Build inflight = 4 across r1 and r4, then reset asynchronously mid-cycle.
        issue_wr(1); step();
        issue_wr(4); step(); step();
        idle();
        chk("pre_async_inflight", inflight, 4);
        chk("pre_async_busy", busy, 8'h12);
        #2 reset = 1;
        #1;
        chk("async_busy", busy, 8'h00);
        chk("async_inflight", inflight, 0);
        chk("async_err", sb_err, 0);
        step();
        reset = 0;
        // Pending entries were discarded, so a late writeback underflows.
        wb_we4 = 1; wb_wa4 = 4;
        step();
        idle();
        chk("late_wb_err", sb_err, 1);
        chk("late_wb_inflight", inflight, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: iss_valid  in  1  decode presents an instruction this cycle.
REQ-004 SHALL have: iss_ra1, iss_ra2  in  3 each  source register addresses (same encoding as regfile ra1/ra2).
REQ-005 SHALL have: iss_use1, iss_use2  in  1 each  corresponding source operand is actually read.
REQ-006 SHALL have: iss_wr  in  1  instruction writes a destination register.
REQ-007 SHALL have: iss_wa  in  3  destination register address.
REQ-008 SHALL have: wb_we3, wb_we4  in  1 each  writeback enables; the same signals driving regfile we3/we4.
REQ-009 SHALL have: wb_wa3, wb_wa4  in  3 each  writeback addresses; the same signals driving regfile wa3/wa4.
REQ-010 SHALL have: stall  out  1  combinational; decode holds the instruction.
REQ-011 SHALL have: iss_accept  out  1  combinational; equals iss_valid & ~stall.
REQ-012 SHALL have: busy  out  8  registered; bit r set when pending count of register r is non-zero.
REQ-013 SHALL have: inflight  out  5  registered; sum of all pending counts, range 0..24.
REQ-014 SHALL have: sb_err  out  1  registered, sticky protocol-error flag.

Function
REQ-015 SHALL keep one 2-bit pending counter cnt[r] per register r = 0..7 (8 registers, 8-bit data path).
REQ-016 stall SHALL be 1 only when iss_valid and any holds: (iss_use1 & busy[iss_ra1] & ~byp1), (iss_use2 & busy[iss_ra2] & ~byp2), or (iss_wr & cnt[iss_wa]==3).
REQ-017 With iss_valid=0, stall SHALL be 0.
REQ-018 On posedge with iss_accept & iss_wr, cnt[iss_wa] SHALL increment by 1.
REQ-019 On posedge, each asserted wb port SHALL decrement cnt[wb_waN] by 1. Both ports at the same address SHALL decrement by 2.
REQ-020 Increment and decrement hitting the same register in one cycle SHALL be summed; net change is in -2..+1.
REQ-021 A decrement below 0 SHALL saturate the counter at 0 and set sb_err. No other counter is affected.
REQ-022 WAW hazards SHALL NOT stall below count 3. In-order writeback per register is the pipeline's responsibility.
REQ-023 inflight SHALL equal the sum of the cnt values after each update, with no off-by-one lag.
REQ-024 Writeback visibility: a wb in cycle N SHALL clear busy from cycle N+1. The regfile writes on negedge within cycle N, so data read in N+1 is valid.
REQ-025 sb_err SHALL remain 1 until reset.

Reset
REQ-026 While reset=1, and asynchronously on its assertion: all cnt=0, busy=8'h00, inflight=0, sb_err=0.
REQ-027 Reset mid-operation SHALL discard all pending entries. Writebacks arriving after reset release SHALL set sb_err per REQ-021.
REQ-028 stall SHALL still evaluate combinationally during reset. Counts are zero, so only iss_valid matters and stall=0.

Configuration
REQ-029 Macro SCOREBOARD_FWD_EN SHALL control same-cycle writeback bypass.
REQ-030 With SCOREBOARD_FWD_EN defined: bypN=1 when cnt[iss_raN]==1 and a wb port writes iss_raN this cycle. The negedge regfile write makes data available in-cycle.
REQ-031 Without SCOREBOARD_FWD_EN: bypN is constant 0; a source stalls until busy clears (one extra cycle).

Verification
REQ-032 Reset, then issue wr wa=3 -> busy=8'h08, inflight=1. Next cycle issue use1 ra1=3 -> stall=1, iss_accept=0.
REQ-033 cnt[3]=1, wb_we3=1 wa3=3 while issuing ra1=3. With SCOREBOARD_FWD_EN: stall=0. Without: stall=1 that cycle, stall=0 next cycle.
REQ-034 Three accepted writes to r5 -> cnt[5]=3, inflight=3. Fourth write to r5 -> stall=1. Same cycle wb_we4 wa4=5 -> count 2 next cycle, fourth accepted the cycle after.
REQ-035 Issue wr wa=2 together with wb_we3 wa3=2 (cnt[2]=1) -> cnt[2] stays 1, busy[2]=1, inflight unchanged.
REQ-036 cnt[6]=1, both wb ports address 6 -> cnt[6]=0, sb_err=1 and stays 1. A wb to idle r0 also sets sb_err.
REQ-037 With inflight=4 across r1/r4, assert reset asynchronously mid-cycle -> busy=0, inflight=0, sb_err=0 before the next clk edge.
